mux41_scan_ctrl: RTL and testbench
==================================

// Module: mux41_scan_ctrl
// PURPOSE
//   Select sequencer and result collector placed directly around the 4:1 mux benchmark.
//   Drives the mux select pair {s1,s0} through channels 0..3 and holds each select
//   stable for a settle window to cover FCN clock-zone latency. Samples the mux output
//   per channel, packs the four samples into one word, and hands it off via valid/ready.
// PARAMETERS
//   HOLD_CYCLES  2  cycles sel is held before sampling; legal range 1..15
//   CNT_W        4  settle counter width; must hold HOLD_CYCLES
// PORTS
//   clk          in   1  single clock, rising edge
//   rst_n        in   1  synchronous, active-low reset
//   start        in   1  begin one scan; acted on only in IDLE
//   sel          out  2  mux select; sel[1]=s1, sel[0]=s0
//   mux_out      in   1  mux result for the current sel
//   word         out  4  word[k] = sample of channel k
//   word_valid   out  1  word is complete and stable
//   word_ready   in   1  consumer accepts word
//   busy         out  1  high from start acceptance until handshake completes
//   ch_mask      in   4  channel enable; present only with MUX_SCAN_MASK_EN
// BEHAVIOUR
//   - Reset (rst_n=0 at an edge): state=IDLE, sel=0, word=0, word_valid=0, busy=0,
//     cnt=0. Applies from any state; a scan in progress is abandoned, no partial word.
//   - IDLE:   start=1 -> word<=0, sel<=0, cnt<=0, busy<=1, go to SETTLE.
//   - SETTLE: sel constant; cnt increments each cycle.
//     cnt==HOLD_CYCLES-1 -> go to SAMPLE, cnt<=0.
//   - SAMPLE: word[sel]<=mux_out.
//     sel==3 -> DONE.  Otherwise sel<=sel+1 and go to SETTLE.
//   - DONE:   word_valid=1, word frozen.
//     word_valid&word_ready -> IDLE. word_valid and busy drop the next cycle.
//     sel keeps its last value.
//   - start outside IDLE is ignored, including start coincident with the DONE handshake.
//     start must be re-asserted while in IDLE.
//   - Latency: start seen at edge T -> channel k sampled at edge T+(k+1)(HOLD_CYCLES+1).
//     word_valid is high after edge T+4(HOLD_CYCLES+1)+1.
//   - word_ready may be held high while waiting; it has no effect outside DONE.
//   - sel never wraps inside a scan; it advances 0->1->2->3 only.
//   - busy is registered and equals (state!=IDLE).
// CONFIGURATION
//   MUX_SCAN_MASK_EN defined:
//     - ch_mask port exists and is captured on the start edge; later changes are ignored.
//     - Disabled channels are skipped with no SETTLE/SAMPLE cycles, and their word bit stays 0.
//     - sel jumps directly to the next enabled channel.
//     - ch_mask==0: IDLE->DONE in one cycle with word=0.
//   MUX_SCAN_MASK_EN undefined: no ch_mask port; all four channels are always scanned.
// STRUCTURE
//   mux_scan_pkg:
//     - NUM_CH=4 and SEL_W=2.
//     - typedef enum {IDLE,SETTLE,SAMPLE,DONE} scan_state_t.
//   Sub-module mux_scan_settle_cnt: the settle counter, with clear/enable inputs and a
//   terminal-count output. FSM and word register stay in the top module.
// TESTING
//   1. HOLD=2; mux_out driven as a model of the 4:1 mux with i0..i3=1,0,1,1.
//      Pulse start at cycle 0 -> word_valid high cycle 13, word=4'b1101.
//   2. word_ready held low for 5 cycles in DONE -> word and valid stable throughout;
//      ready=1 -> valid=0 and busy=0 the next cycle.
//   3. start pulsed mid-scan and again in the DONE-handshake cycle -> no restart.
//      Exactly one word is produced.
//   4. rst_n=0 for one edge during channel 2 SETTLE -> all outputs return to reset values.
//      A following start yields a correct full word.
//   5. MUX_SCAN_MASK_EN, ch_mask=4'b0101, all inputs 1 -> sel visits only 0 and 2;
//      word=4'b0101; valid after 2(HOLD+1)+1 cycles.
//   6. MUX_SCAN_MASK_EN, ch_mask=0 -> word_valid one cycle after start, word=0.

Source files
------------

// File: rtl/mux_scan_pkg.sv
// Shared types for the 4:1 mux scan controller: channel count, select width, FSM states.
// Also holds the channel search helper. Pure declarations, so no latency or backpressure.
package mux_scan_pkg;
  localparam int NUM_CH = 4;
  localparam int SEL_W  = 2;

  typedef enum logic [1:0] {IDLE, SETTLE, SAMPLE, DONE} scan_state_t;

  // Returns {found, index}: the lowest enabled channel at or above 'from'.
  function automatic logic [SEL_W:0] next_ch(input logic [NUM_CH-1:0] mask, input int from);
    logic [SEL_W:0] r;
    r = '0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (i >= from && mask[i]) r = {1'b1, SEL_W'(i)};
    end
    return r;
  endfunction
endpackage

// File: rtl/mux_scan_settle_cnt.sv
// Settle window counter: terminal count while cnt==HOLD_CYCLES-1, then wraps to 0.
// Takes effect one cycle after en_i. clr_i has priority over en_i; there is no backpressure.
module mux_scan_settle_cnt #(
  parameter int HOLD_CYCLES = 2,
  parameter int CNT_W       = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr_i,
  input  logic en_i,
  output logic tc_o
);
  logic [CNT_W-1:0] cnt_q, cnt_d;

  assign tc_o = (cnt_q == CNT_W'(HOLD_CYCLES - 1));

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i)     cnt_d = '0;
    else if (en_i) cnt_d = tc_o ? '0 : cnt_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end
endmodule

// File: rtl/mux41_scan_ctrl.sv
// Steps the mux select through each channel and packs the samples into a word. Valid rises N*(HOLD+1)+1 cycles after start.
// The word holds until word_ready is accepted. Define MUX_SCAN_MASK_EN to add ch_mask channel skipping.
module mux41_scan_ctrl
  import mux_scan_pkg::*;
#(
  parameter int HOLD_CYCLES = 2,
  parameter int CNT_W       = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  output logic [SEL_W-1:0]     sel,
  input  logic                 mux_out,
  output logic [NUM_CH-1:0]    word,
  output logic                 word_valid,
  input  logic                 word_ready,
  output logic                 busy
`ifdef MUX_SCAN_MASK_EN
  ,
  input  logic [NUM_CH-1:0]    ch_mask
`endif
);
  scan_state_t       state_q, state_d;
  logic [SEL_W-1:0]  sel_q, sel_d;
  logic [NUM_CH-1:0] word_q, word_d;
  logic [NUM_CH-1:0] mask_q, mask_d;
  logic [NUM_CH-1:0] start_mask;
  logic              valid_q, valid_d;
  logic              busy_q;
  logic              cnt_clr, cnt_en, cnt_tc;
  logic [SEL_W:0]    nxt;

  // Without masking every channel is enabled, so both builds share one datapath.
`ifdef MUX_SCAN_MASK_EN
  assign start_mask = ch_mask;
`else
  assign start_mask = '1;
`endif

  mux_scan_settle_cnt #(
    .HOLD_CYCLES (HOLD_CYCLES),
    .CNT_W       (CNT_W)
  ) u_settle_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .clr_i (cnt_clr),
    .en_i  (cnt_en),
    .tc_o  (cnt_tc)
  );

  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    word_d  = word_q;
    mask_d  = mask_q;
    valid_d = valid_q;
    cnt_clr = 1'b0;
    cnt_en  = 1'b0;
    nxt     = '0;
    case (state_q)
      IDLE: begin
        cnt_clr = 1'b1;
        if (start) begin
          word_d  = '0;
          mask_d  = start_mask;
          nxt     = next_ch(start_mask, 0);
          sel_d   = nxt[SEL_W] ? nxt[SEL_W-1:0] : '0;
          state_d = nxt[SEL_W] ? SETTLE : DONE;
        end
      end
      SETTLE: begin
        cnt_en = 1'b1;
        if (cnt_tc) state_d = SAMPLE;
      end
      SAMPLE: begin
        word_d[sel_q] = mux_out;
        nxt = next_ch(mask_q, int'(sel_q) + 1);
        if (nxt[SEL_W]) begin
          sel_d   = nxt[SEL_W-1:0];
          state_d = SETTLE;
        end else begin
          state_d = DONE;
        end
      end
      DONE: begin
        valid_d = 1'b1;
        if (valid_q && word_ready) begin
          valid_d = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      sel_q   <= '0;
      word_q  <= '0;
      mask_q  <= '0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      word_q  <= word_d;
      mask_q  <= mask_d;
      valid_q <= valid_d;
      busy_q  <= (state_d != IDLE);
    end
  end

  assign sel        = sel_q;
  assign word       = word_q;
  assign word_valid = valid_q;
  assign busy       = busy_q;
endmodule

// File: tb/tb_mux41_scan_ctrl.sv
// Randomized scoreboard bench for mux41_scan_ctrl.
// The mux model feeds the DUT. Expected words and valid cycles are queued at start, then checked by the monitor.
module tb_mux41_scan_ctrl;
  localparam int HOLD = 2;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic       word_ready = 1'b0;
  logic [1:0] sel;
  logic       mux_out;
  logic [3:0] word;
  logic       word_valid;
  logic       busy;
  logic [3:0] in_vec = 4'b0;
`ifdef MUX_SCAN_MASK_EN
  logic [3:0] ch_mask = 4'hF;
`endif

  typedef struct {
    logic [3:0] w;
    int         t;
  } exp_t;

  exp_t       exp_q[$];
  int         n_cmp = 0;
  int         n_bad = 0;
  int         cyc = 0;
  logic [3:0] sel_seen = 4'b0;

  assign mux_out = in_vec[sel];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  mux41_scan_ctrl #(.HOLD_CYCLES(HOLD), .CNT_W(4)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .sel        (sel),
    .mux_out    (mux_out),
    .word       (word),
    .word_valid (word_valid),
    .word_ready (word_ready),
    .busy       (busy)
`ifdef MUX_SCAN_MASK_EN
    ,
    .ch_mask    (ch_mask)
`endif
  );

  function automatic int popc(input logic [3:0] m);
    int n;
    n = 0;
    for (int i = 0; i < 4; i++) n += int'(m[i]);
    return n;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  // Monitor: samples 1 time unit after each rising edge.
  initial begin : monitor
    logic       prev_v;
    logic       hs_pend;
    logic [3:0] held;
    exp_t       e;
    prev_v  = 1'b0;
    hs_pend = 1'b0;
    held    = 4'b0;
    forever begin
      @(posedge clk);
      #1;
      if (!rst_n) begin
        prev_v  = 1'b0;
        hs_pend = 1'b0;
      end else begin
        if (busy) sel_seen[sel] = 1'b1;
        if (hs_pend) begin
          check("valid_drop", {31'b0, word_valid}, 32'd0);
          check("busy_drop", {31'b0, busy}, 32'd0);
        end
        if (word_valid && !prev_v) begin
          if (exp_q.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL unexpected_word: got %0h expected none at cycle %0d", word, cyc);
          end else begin
            e = exp_q.pop_front();
            check("word", {28'b0, word}, {28'b0, e.w});
            check("valid_cycle", cyc, e.t);
            check("busy_in_done", {31'b0, busy}, 32'd1);
          end
          held = word;
        end else if (word_valid && prev_v) begin
          check("word_stable", {28'b0, word}, {28'b0, held});
        end
        hs_pend = word_valid && word_ready;
        prev_v  = word_valid;
      end
    end
  end

  task automatic issue(input logic [3:0] iv, input logic [3:0] m);
    logic [3:0] em;
    exp_t       e;
    @(negedge clk);
    in_vec = iv;
`ifdef MUX_SCAN_MASK_EN
    ch_mask = m;
    em = m;
`else
    em = 4'hF;
    if (m != em) em = 4'hF;
`endif
    start = 1'b1;
    e.w = iv & em;
    e.t = cyc + 1 + popc(em) * (HOLD + 1) + 1;
    exp_q.push_back(e);
    @(negedge clk);
    start = 1'b0;
`ifdef MUX_SCAN_MASK_EN
    ch_mask = 4'($urandom);
`endif
  endtask

  task automatic wait_valid(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (word_valid) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      n_cmp++;
      n_bad++;
      $display("FAIL valid_timeout: got no word_valid expected one within 300 cycles");
    end
  endtask

  task automatic drain(input int d);
    bit ok;
    wait_valid(ok);
    if (ok) begin
      repeat (d) @(negedge clk);
      word_ready = 1'b1;
      @(negedge clk);
      word_ready = 1'b0;
    end
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    bit ok;
    repeat (2) @(negedge clk);
    check("rst_sel", {30'b0, sel}, 32'd0);
    check("rst_word", {28'b0, word}, 32'd0);
    check("rst_valid", {31'b0, word_valid}, 32'd0);
    check("rst_busy", {31'b0, busy}, 32'd0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Directed scan with i0..i3 = 1,0,1,1.
    issue(4'b1101, 4'hF);
    drain(0);

    // Consumer stalls for five cycles in DONE.
    issue(4'($urandom), 4'hF);
    drain(5);

    // Starts mid-scan and on the handshake cycle are ignored.
    issue(4'($urandom), 4'hF);
    repeat (5) @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_valid(ok);
    word_ready = 1'b1;
    start = 1'b1;
    @(negedge clk);
    word_ready = 1'b0;
    start = 1'b0;
    repeat (30) @(negedge clk);
    check("no_restart_busy", {31'b0, busy}, 32'd0);
    check("no_restart_queue", exp_q.size(), 32'd0);

    // Reset during the channel 2 settle window.
    issue(4'($urandom), 4'hF);
    ok = 1'b0;
    for (int i = 0; i < 100; i++) begin
      if (sel == 2'd2) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    check("reach_ch2", {31'b0, ok}, 32'd1);
    rst_n = 1'b0;
    @(negedge clk);
    exp_q.delete();
    check("mid_rst_sel", {30'b0, sel}, 32'd0);
    check("mid_rst_word", {28'b0, word}, 32'd0);
    check("mid_rst_valid", {31'b0, word_valid}, 32'd0);
    check("mid_rst_busy", {31'b0, busy}, 32'd0);
    rst_n = 1'b1;
    issue(4'($urandom), 4'hF);
    drain(1);

`ifdef MUX_SCAN_MASK_EN
    @(negedge clk);
    sel_seen = 4'b0;
    issue(4'hF, 4'b0101);
    drain(0);
    check("mask_sel_visits", {28'b0, sel_seen}, 32'h5);
    issue(4'hF, 4'b0000);
    drain(0);
`endif

    // Randomized scans with random consumer delay and occasional early ready.
    for (int n = 0; n < 20; n++) begin
      word_ready = ($urandom_range(0, 3) == 0);
      issue(4'($urandom), 4'($urandom));
      drain($urandom_range(0, 4));
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end

    repeat (5) @(negedge clk);
    check("queue_empty", exp_q.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
